// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared defaults, state encoding and NOP word for the instruction fetch unit
package ifu_pkg;

  localparam int IFU_ADDR_W   = 6;
  localparam int IFU_INSTR_W  = 32;
  localparam int IFU_CNT_W    = 16;
  localparam int IFU_RESET_PC = 0;

  localparam logic [31:0] NOP_WORD = 32'h0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } ifu_state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - program counter with increment/wrap and absolute redirect load
module fetch_pc_gen
  import ifu_pkg::*;
#(
  parameter int ADDR_W   = IFU_ADDR_W,
  parameter int RESET_PC = IFU_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_adv,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  // Redirect outranks the sequential step; natural overflow gives the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= ADDR_W'(RESET_PC);
    end else if (i_redirect_valid) begin
      r_pc <= i_redirect_pc;
    end else if (i_adv) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch FSM, instruction register, decode handshake and capture counter
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int ADDR_W   = IFU_ADDR_W,
  parameter int INSTR_W  = IFU_INSTR_W,
  parameter int RESET_PC = IFU_RESET_PC,
  parameter int CNT_W    = IFU_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ir_out,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               dec_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  input  logic               start,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  ifu_state_e         r_state;
  ifu_state_e         w_state_nxt;
  logic [INSTR_W-1:0] r_ir_out;
  logic [ADDR_W-1:0]  r_ir_pc;
  logic               r_ir_valid;
  logic [CNT_W-1:0]   r_fetch_count;
  logic [ADDR_W-1:0]  w_pc;
  logic               w_adv;
  logic               w_capture;
  logic               w_halted;

  assign w_adv = !r_ir_valid || dec_ready;

  fetch_pc_gen #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_adv            (w_capture),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_pc             (w_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // halt_req dominates start, and a redirect never alters the state decision.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:    if (halt_req) w_state_nxt = ST_HALTED;
      ST_HALTED: if (start && !halt_req) w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_halted  = (r_state == ST_HALTED);
    w_capture = (r_state == ST_RUN) && w_adv && !redirect_valid;
  end

  // A redirect drops the held word even if decode is accepting it this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir_out   <= INSTR_W'(NOP_WORD);
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
    end else if (redirect_valid) begin
      r_ir_valid <= 1'b0;
    end else if (w_capture) begin
      r_ir_out   <= imem_data;
      r_ir_pc    <= w_pc;
      r_ir_valid <= 1'b1;
    end else if (r_ir_valid && dec_ready) begin
      r_ir_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
    end else if (w_capture) begin
      r_fetch_count <= r_fetch_count + CNT_W'(1);
    end
  end

  assign imem_addr   = w_pc;
  assign ir_out      = r_ir_out;
  assign ir_pc       = r_ir_pc;
  assign ir_valid    = r_ir_valid;
  assign halted      = w_halted;
  assign fetch_count = r_fetch_count;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory interface.
- Owns the program counter and drives the word address to the combinational instruction ROM. Captures the returned 32-bit word into an instruction register and presents it to decode over a valid/ready handshake.
- Supports absolute redirect (branch/jump flush), halt and restart.
- Sits between the instruction ROM and the decode stage of the 16-bit Harvard core.

Parameters:
ADDR_W, 6, PC/ROM word-address width; PC wraps modulo 2^ADDR_W.
INSTR_W, 32, instruction word width.
RESET_PC, 0, PC value loaded on reset.
CNT_W, 16, width of fetch counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
imem_addr  output  ADDR_W  word address to instruction ROM; equals pc register
imem_data  input  INSTR_W  ROM read data, combinational from imem_addr, valid same cycle
ir_out  output  INSTR_W  captured instruction to decode
ir_pc  output  ADDR_W  address ir_out was fetched from
ir_valid  output  1  ir_out/ir_pc hold a live instruction
dec_ready  input  1  decode accepts ir_out this cycle
redirect_valid  input  1  one-cycle request to load new PC and flush
redirect_pc  input  ADDR_W  absolute redirect target
halt_req  input  1  stop fetching
start  input  1  leave HALTED and resume at current pc
halted  output  1  high while in HALTED
fetch_count  output  CNT_W  number of captures since reset; wraps

Behaviour:
- Reset (async, rst_n low): pc=RESET_PC, ir_out=0, ir_pc=0, ir_valid=0, fetch_count=0, state=RUN, halted=0. Release is sampled at the next clk edge.
- States: RUN, HALTED.
- Advance condition: adv = (!ir_valid || dec_ready). A handshake completes when ir_valid && dec_ready.
- RUN, no redirect, adv=1:
  - ir_out<=imem_data, ir_pc<=pc, ir_valid<=1, pc<=pc+1 (ADDR_W wrap: 2^ADDR_W-1 -> 0), fetch_count<=fetch_count+1.
  - One instruction per cycle at full throughput.
- RUN, adv=0: pc, ir_out, ir_pc and ir_valid hold. ROM address is stable.
- Fetch latency: address presented in cycle N; instruction visible on ir_out with ir_valid in cycle N+1.
- Redirect (any state, highest priority):
  - pc<=redirect_pc; ir_valid<=0, so the held instruction is discarded even if dec_ready=1 that cycle.
  - No capture that cycle and fetch_count unchanged.
  - First post-redirect instruction is valid two cycles after the redirect edge's cycle.
- halt_req in RUN:
  - state<=HALTED at the next edge. The capture that same cycle still occurs if adv=1 and no redirect.
  - In HALTED: no captures, pc holds, ir_valid clears on its handshake and otherwise holds.
- HALTED: halted=1. Redirect updates pc and flushes but state stays HALTED. start with halt_req=0 -> RUN next edge.
- Simultaneous events:
  - start && halt_req -> halt wins.
  - redirect && halt_req -> redirect applied and state -> HALTED.
- ROM default word (all zeros) is passed through unmodified; no decode-level interpretation here.
- fetch_count wraps at 2^CNT_W-1 -> 0.
- Reset asserted mid-handshake: all state cleared asynchronously; in-flight instruction lost.

Decomposition:
- Package ifu_pkg: ADDR_W/INSTR_W defaults, RESET_PC, state enum {RUN, HALTED}, NOP_WORD = 32'h0.
- One sub-module fetch_pc_gen: pc register with increment/wrap, redirect mux and reset value; outputs pc and accepts adv/redirect.
- Top holds the FSM, IR, handshake and counter.

Test Plan:
- Reset then dec_ready=1, ROM {0:32'h00200003, 1:32'h00200003, 2:32'h10640022, others 0} -> ir_out sequence 00200003, 00200003, 10640022, 0... with ir_pc 0,1,2,3; fetch_count=3 after third capture.
- dec_ready=0 for 3 cycles after first capture -> ir_out holds 00200003/ir_pc=0, imem_addr stays 1, fetch_count stays 1; release -> ir_pc=1 next.
- redirect_valid with redirect_pc=2 while ir_valid=1 (ir_pc=0) and dec_ready=1 -> ir_valid=0 next cycle, then ir_out=10640022, ir_pc=2; fetch_count not incremented in redirect cycle.
- Run to pc=63 -> next ir_pc=63 then 0 (wrap); ir_out=0 for addr 63.
- halt_req at pc=1 -> halted=1 next cycle, no further captures over 5 cycles; start -> resumes with ir_pc=2 (or the pc held).
- Assert rst_n low mid-stream between edges -> outputs zero immediately, pc=0; after release, first ir_out=00200003 at ir_pc=0.
